// File: rtl/alu_operand_serializer_pkg.sv
// Shared definitions for the ALU operand serializer: default widths, beat
// count, FSM state encoding and a helper for computing the beat count.
package alu_operand_serializer_pkg;

    localparam int OPERAND_WIDTH_DEF     = 32;
    localparam int OPERAND_BUS_WIDTH_DEF = 8;
    localparam int BEATS_DEF             = OPERAND_WIDTH_DEF / OPERAND_BUS_WIDTH_DEF;

    // IDLE: waiting for a request. SEND: streaming beats of a captured request.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Number of bus beats needed for one full operand. A zero bus width is
    // reported elsewhere as an error, so it maps to zero beats here.
    function automatic int calc_beats(input int width, input int bus_width);
        return (bus_width == 0) ? 0 : width / bus_width;
    endfunction

endpackage

// File: rtl/alu_operand_serializer.sv
// Splits a full-width ALU request (opcode plus operands A and B) into a
// sequence of narrow operand beats, least-significant slice first.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The upstream side (req_valid/req_ready) and the downstream side
// (operand_valid/ready) both follow this rule; once operand_valid is high, the
// beat contents stay frozen until the beat is taken.
module alu_operand_serializer
    import alu_operand_serializer_pkg::*;
#(
    parameter int OPERAND_WIDTH     = OPERAND_WIDTH_DEF,
    parameter int OPERAND_BUS_WIDTH = OPERAND_BUS_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_op,
    input  logic [OPERAND_WIDTH-1:0]     req_a,
    input  logic [OPERAND_WIDTH-1:0]     req_b,
    output logic                         operand_valid,
    output logic [2:0]                   op,
    output logic [OPERAND_BUS_WIDTH-1:0] a,
    output logic [OPERAND_BUS_WIDTH-1:0] b,
    output logic                         operand_last,
    input  logic                         ready
);

    localparam int BEATS = calc_beats(OPERAND_WIDTH, OPERAND_BUS_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // The operand must split into a whole, nonzero number of beats.
    generate
        if (OPERAND_BUS_WIDTH <= 0 || OPERAND_WIDTH <= 0 ||
            (OPERAND_WIDTH % OPERAND_BUS_WIDTH) != 0) begin : g_bad_width
            $error("alu_operand_serializer: OPERAND_WIDTH must be a nonzero multiple of OPERAND_BUS_WIDTH");
        end
    endgenerate

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         cnt_inc;
    logic [OPERAND_WIDTH-1:0] a_rem;
    logic [OPERAND_WIDTH-1:0] b_rem;
    logic                     accept;
    logic                     beat_hs;
    logic                     last_hs;

    // A new request may enter while idle, or in the same edge as the final
    // beat of the current transaction is taken, so back-to-back requests
    // stream without a gap.
    assign beat_hs   = operand_valid && ready;
    assign last_hs   = beat_hs && operand_last;
    assign req_ready = (state == IDLE) || last_hs;
    assign accept    = req_valid && req_ready;
    assign cnt_inc   = beat_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stay in SEND when a new request chains onto the last beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SEND;
            SEND:    if (last_hs && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat datapath: load slice 0 on acceptance, then shift the remaining
    // slices out one per downstream handshake. Outputs are all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt      <= '0;
            a_rem         <= '0;
            b_rem         <= '0;
            a             <= '0;
            b             <= '0;
            op            <= '0;
            operand_valid <= 1'b0;
            operand_last  <= 1'b0;
        end else if (accept) begin
            a_rem         <= req_a >> OPERAND_BUS_WIDTH;
            b_rem         <= req_b >> OPERAND_BUS_WIDTH;
            a             <= req_a[OPERAND_BUS_WIDTH-1:0];
            b             <= req_b[OPERAND_BUS_WIDTH-1:0];
            op            <= req_op;
            beat_cnt      <= '0;
            operand_valid <= 1'b1;
            operand_last  <= (BEATS == 1);
        end else if (beat_hs) begin
            if (operand_last) begin
                // Transaction done: a, b and op keep their last values.
                beat_cnt      <= '0;
                operand_valid <= 1'b0;
                operand_last  <= 1'b0;
            end else begin
                a_rem        <= a_rem >> OPERAND_BUS_WIDTH;
                b_rem        <= b_rem >> OPERAND_BUS_WIDTH;
                a            <= a_rem[OPERAND_BUS_WIDTH-1:0];
                b            <= b_rem[OPERAND_BUS_WIDTH-1:0];
                beat_cnt     <= cnt_inc;
                operand_last <= (cnt_inc == LAST_BEAT);
            end
        end
    end

endmodule

// File: doc/alu_operand_serializer.md
ALU_OPERAND_SERIALIZER -- requirements
Module: alu_operand_serializer

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32: full operand width on the request side.
REQ-002 SHALL have parameter OPERAND_BUS_WIDTH, default 8: ALU operand bus width per beat.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: upstream request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port req_op, input, 3: ALU opcode.
REQ-008 SHALL have port req_a, input, OPERAND_WIDTH: full operand A.
REQ-009 SHALL have port req_b, input, OPERAND_WIDTH: full operand B.
REQ-010 SHALL have port operand_valid, output, 1: beat valid toward ALU.
REQ-011 SHALL have port op, output, 3: opcode of current transaction.
REQ-012 SHALL have port a, output, OPERAND_BUS_WIDTH: current slice of A.
REQ-013 SHALL have port b, output, OPERAND_BUS_WIDTH: current slice of B.
REQ-014 SHALL have port operand_last, output, 1: marks final beat of the transaction.
REQ-015 SHALL have port ready, input, 1: ALU accepts beat when operand_valid && ready at a rising edge.

Function
REQ-016 SHALL split each request into BEATS = OPERAND_WIDTH/OPERAND_BUS_WIDTH beats, least-significant slice first.
REQ-017 SHALL use FSM states IDLE and SEND; IDLE->SEND on request acceptance; SEND->IDLE on last-beat handshake with no new request accepted.
REQ-018 SHALL drive req_ready = (state==IDLE) || (operand_valid && ready && operand_last), giving back-to-back transactions with no bubble beat.
REQ-019 SHALL present beat 0 (operand_valid=1) in the cycle after request acceptance: latency one cycle.
REQ-020 SHALL hold op, a, b, operand_last, operand_valid stable while operand_valid && !ready.
REQ-021 SHALL advance the beat counter only on an operand_valid && ready handshake; counter wraps to 0 after beat BEATS-1.
REQ-022 SHALL assert operand_last only on beat BEATS-1; if BEATS==1 every beat is last.
REQ-023 SHALL keep op constant across all beats of one transaction.
REQ-024 SHALL ignore req_valid and leave req_a/req_b/req_op uncaptured while req_ready=0.
REQ-025 SHALL drive all downstream outputs from registers (no combinational path from req_* to a/b/op).
REQ-026 SHALL deassert operand_valid in IDLE; a, b, op retain last values there.

Reset
REQ-027 SHALL, on rst low, asynchronously force state=IDLE, beat counter=0, operand_valid=0, operand_last=0, op=0, a=0, b=0, capture registers=0.
REQ-028 SHALL abandon any in-flight transaction on reset; the first request after release starts at beat 0.
REQ-029 SHALL present req_ready=1 in the first cycle after reset release.

Structure
REQ-030 SHALL take OPERAND_WIDTH and OPERAND_BUS_WIDTH defaults, localparam BEATS, and the FSM state enum typedef from package parameters.
REQ-031 SHALL flag an elaboration error if OPERAND_WIDTH is not a nonzero multiple of OPERAND_BUS_WIDTH.
REQ-032 SHALL be a single module with no sub-module; downstream ports map one-to-one onto the ALU_in_if driver_mp signals.

Verification (OPERAND_WIDTH=32, OPERAND_BUS_WIDTH=8)
REQ-033 SHALL cover: req_a=0x44332211, req_b=0x88776655, req_op=3'b010, ready=1 -> a=11,22,33,44; b=55,66,77,88 on four consecutive cycles; op=2 throughout; operand_last only on beat 4.
REQ-034 SHALL cover: ready=0 for 3 cycles while beat 2 shown -> a=0x22, b=0x66, operand_valid=1 held 4 cycles, then beat 3 follows.
REQ-035 SHALL cover: two requests, second held valid -> second accepted on the last-beat handshake of the first; 8 consecutive valid beats, operand_last on beats 4 and 8.
REQ-036 SHALL cover: rst low for one cycle after beat 2 handshake -> operand_valid=0 immediately, req_ready=1 after release, new request starts with slice 0.
REQ-037 SHALL cover: req_valid toggled with new data during SEND -> req_ready=0, outputs unaffected, original beats complete unchanged.
